vga_timing_generator_param: RTL and testbench
=============================================

Name: vga_timing_generator_param

Overview:
Parametrised successor to the fixed 640x480 VGA timing generator. Divides the 100 MHz system clock down to a pixel tick and produces hsync, vsync, video_on and pixel coordinates for any resolution and porch set given by parameters. Adds programmable sync polarity, line-start and frame-start strobes, and a frame counter. Sits between the system clock domain and the pixel/RGB generation logic.

Parameters:
CLK_DIV, 4, system clocks per pixel tick (>=1)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
CW, 10, width of pixel_x/pixel_y counters; must hold H_TOTAL-1 and V_TOTAL-1
FRAME_W, 8, width of frame_count

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-high reset
hsync  output  1  horizontal sync, level per HS_POL
vsync  output  1  vertical sync, level per VS_POL
video_on  output  1  high while pixel_x < H_ACTIVE and pixel_y < V_ACTIVE
p_tick  output  1  one-clk pulse each pixel period
pixel_x  output  CW  horizontal counter, 0..H_TOTAL-1
pixel_y  output  CW  vertical counter, 0..V_TOTAL-1
line_start  output  1  one-clk pulse when pixel_x wraps to 0
frame_start  output  1  one-clk pulse when (pixel_x,pixel_y) wraps to (0,0)
frame_count  output  FRAME_W  completed-frame counter, wraps mod 2^FRAME_W

Behaviour:
- One clock (clk); reset synchronous, active-high; all state changes on rising clk edge.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Divider div counts 0..CLK_DIV-1; p_tick = 1 for the clk cycle where div == CLK_DIV-1. CLK_DIV=1: p_tick high every cycle outside reset.
- On p_tick: pixel_x increments; at H_TOTAL-1 wraps to 0 and pixel_y increments; pixel_y at V_TOTAL-1 wraps to 0 together with pixel_x.
- hsync active when H_ACTIVE+H_FP <= pixel_x <= H_ACTIVE+H_FP+H_SYNC-1; vsync active when V_ACTIVE+V_FP <= pixel_y <= V_ACTIVE+V_FP+V_SYNC-1; otherwise at inactive level.
- hsync, vsync, video_on, line_start, frame_start are registered, decoded from next-state counters: they change on the same edge as pixel_x/pixel_y, no skew.
- line_start/frame_start: high for exactly one clk, the cycle after the wrapping edge; frame_count increments on the same edge frame_start rises.
- Reset values: div=0, pixel_x=0, pixel_y=0, p_tick=0, hsync=~HS_POL, vsync=~VS_POL, video_on=1, line_start=0, frame_start=0, frame_count=0.
- Reset mid-frame: every output takes its reset value on the next edge; counting resumes from (0,0) with first p_tick CLK_DIV clks after reset deasserts. No frame_start emitted for the reset-induced return to (0,0).
- Counter overflow impossible by construction; CW too small for H_TOTAL/V_TOTAL is a parameter error (elaboration check).

Optional Feature:
VGA_TIMING_PIPE_EN: defined -> hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start delayed by one extra clk register stage (to match a one-cycle pixel-data pipeline); p_tick and frame_count not delayed; stage resets to same reset values. Undefined -> no extra stage, timing as above.

Test Plan:
- Defaults, reset 100 ns then release -> p_tick every 4 clk (40 ns); line_start period 3200 clk (32 us); frame_start period 1,680,000 clk (16.8 ms).
- Defaults -> hsync low exactly for pixel_x 656..751 (384 clk); vsync low exactly for pixel_y 490..491 (6400 clk).
- Defaults -> video_on high for x 0..639 at y 0..479; low at x=640 and at y=480..524.
- Reset asserted at pixel_x=300, pixel_y=200 for 3 clk -> next edge x=0, y=0, hsync/vsync=1, frame_count=0, no frame_start pulse.
- Override CLK_DIV=2, 800/56/120/64, 600/37/6/23, HS_POL=VS_POL=1 -> H_TOTAL=1040, V_TOTAL=666; hsync high for x 856..975; vsync high for y 637..642.
- FRAME_W=2, run 5 frames -> frame_count 1,2,3,0,1; with VGA_TIMING_PIPE_EN defined, hsync falls 1 clk later than undefined build.

Source files
------------

// File: rtl/vga_timing_generator_param.sv
// ---------------------------------------------------------------------------
// vga_timing_generator_param
//
// Parametrised VGA raster timing generator. The system clock is divided down
// to a pixel tick. Each tick advances a horizontal/vertical raster position.
// Sync, blanking and strobe outputs are decoded from that position.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   hsync        horizontal sync; its active level is set by HS_POL
//   vsync        vertical sync; its active level is set by VS_POL
//   video_on     high while inside the visible H_ACTIVE x V_ACTIVE area
//   p_tick       one-clk pulse per pixel period
//   pixel_x      horizontal position, 0..H_TOTAL-1
//   pixel_y      vertical position, 0..V_TOTAL-1
//   line_start   one-clk pulse after pixel_x wraps to 0
//   frame_start  one-clk pulse after (pixel_x,pixel_y) wraps to (0,0)
//   frame_count  completed-frame counter, wraps mod 2^FRAME_W
//
// Optional build macro:
//   VGA_TIMING_PIPE_EN  adds one register stage to hsync, vsync, video_on,
//                       pixel_x, pixel_y, line_start and frame_start. This
//                       lines them up with a one-cycle pixel-data pipeline.
//                       p_tick and frame_count are not delayed.
// ---------------------------------------------------------------------------
module vga_timing_generator_param #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CW       = 10,
    parameter int FRAME_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               p_tick,
    output logic [CW-1:0]      pixel_x,
    output logic [CW-1:0]      pixel_y,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CW-1:0]    X_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0]    Y_LAST   = CW'(V_TOTAL - 1);
    localparam logic             HS_ON    = (HS_POL != 0);
    localparam logic             VS_ON    = (VS_POL != 0);

    // Reject parameter sets the counters cannot represent.
    if (CLK_DIV < 1) begin : g_bad_div
        $error("CLK_DIV must be at least 1");
    end
    if (H_TOTAL > (1 << CW)) begin : g_bad_h
        $error("CW too narrow for H_TOTAL-1");
    end
    if (V_TOTAL > (1 << CW)) begin : g_bad_v
        $error("CW too narrow for V_TOTAL-1");
    end

    function automatic logic in_window(input logic [CW-1:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

    logic [DIV_W-1:0]   div_p0;
    logic               vld_p0;
    logic [CW-1:0]      x_p0, y_p0;
    logic               hs_p0, vs_p0, von_p0, ls_p0, fs_p0;
    logic [FRAME_W-1:0] fc_p0;

    logic [CW-1:0]      x_nx, y_nx;
    logic               line_wrap, frame_wrap;

    // Next raster position. The decoded outputs are registered from this
    // value, so they update on the same edge as the counters.
    always_comb begin
        x_nx       = x_p0;
        y_nx       = y_p0;
        line_wrap  = 1'b0;
        frame_wrap = 1'b0;
        if (vld_p0) begin
            if (x_p0 == X_LAST) begin
                x_nx      = '0;
                line_wrap = 1'b1;
                if (y_p0 == Y_LAST) begin
                    y_nx       = '0;
                    frame_wrap = 1'b1;
                end else begin
                    y_nx = y_p0 + 1'b1;
                end
            end else begin
                x_nx = x_p0 + 1'b1;
            end
        end
    end

    // Stage p0: the divider, the raster counters and the decoded outputs.
    // p_tick is the registered decode of the divider's last count. It
    // therefore stays low during reset, even when CLK_DIV is 1. The first
    // tick arrives CLK_DIV clks after reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_p0 <= '0;
            vld_p0 <= 1'b0;
            x_p0   <= '0;
            y_p0   <= '0;
            hs_p0  <= ~HS_ON;
            vs_p0  <= ~VS_ON;
            von_p0 <= 1'b1;
            ls_p0  <= 1'b0;
            fs_p0  <= 1'b0;
            fc_p0  <= '0;
        end else begin
            div_p0 <= (div_p0 == DIV_LAST) ? '0 : div_p0 + 1'b1;
            vld_p0 <= (div_p0 == DIV_LAST);
            x_p0   <= x_nx;
            y_p0   <= y_nx;
            hs_p0  <= in_window(x_nx, HS_START, HS_END) ? HS_ON : ~HS_ON;
            vs_p0  <= in_window(y_nx, VS_START, VS_END) ? VS_ON : ~VS_ON;
            von_p0 <= (int'(x_nx) < H_ACTIVE) && (int'(y_nx) < V_ACTIVE);
            ls_p0  <= line_wrap;
            fs_p0  <= frame_wrap;
            if (frame_wrap) begin
                fc_p0 <= fc_p0 + 1'b1;
            end
        end
    end

    assign p_tick      = vld_p0;
    assign frame_count = fc_p0;

`ifdef VGA_TIMING_PIPE_EN
    logic [CW-1:0] x_p1, y_p1;
    logic          hs_p1, vs_p1, von_p1, ls_p1, fs_p1;

    // Stage p1: a one-clk delay of the raster-aligned outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_p1   <= '0;
            y_p1   <= '0;
            hs_p1  <= ~HS_ON;
            vs_p1  <= ~VS_ON;
            von_p1 <= 1'b1;
            ls_p1  <= 1'b0;
            fs_p1  <= 1'b0;
        end else begin
            x_p1   <= x_p0;
            y_p1   <= y_p0;
            hs_p1  <= hs_p0;
            vs_p1  <= vs_p0;
            von_p1 <= von_p0;
            ls_p1  <= ls_p0;
            fs_p1  <= fs_p0;
        end
    end

    assign pixel_x     = x_p1;
    assign pixel_y     = y_p1;
    assign hsync       = hs_p1;
    assign vsync       = vs_p1;
    assign video_on    = von_p1;
    assign line_start  = ls_p1;
    assign frame_start = fs_p1;
`else
    assign pixel_x     = x_p0;
    assign pixel_y     = y_p0;
    assign hsync       = hs_p0;
    assign vsync       = vs_p0;
    assign video_on    = von_p0;
    assign line_start  = ls_p0;
    assign frame_start = fs_p0;
`endif

endmodule

// File: tb/tb_vga_timing_generator_param.sv
module tb_vga_timing_generator_param;

    typedef struct packed {
        int d; int ha; int hfp; int hs; int hb;
        int va; int vfp; int vs; int vb; int hp; int vp; int fw;
    } cfg_t;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        von;
        logic        pt;
        logic [15:0] x;
        logic [15:0] y;
        logic        ls;
        logic        fs;
        logic [7:0]  fc;
    } out_t;

    // A: divided clock, active-low hsync, active-high vsync, tight CW.
    // B: CLK_DIV=1, opposite polarities, tight CW.
    localparam cfg_t CFG_A = '{d:3, ha:8, hfp:2, hs:3, hb:2, va:5, vfp:1, vs:2, vb:2, hp:0, vp:1, fw:2};
    localparam cfg_t CFG_B = '{d:1, ha:4, hfp:1, hs:2, hb:1, va:3, vfp:1, vs:1, vb:1, hp:1, vp:0, fw:3};

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_edges = 0;
    int   checks = 0;
    int   errors = 0;

    logic       hsync_a, vsync_a, video_on_a, p_tick_a, line_start_a, frame_start_a;
    logic [3:0] pixel_x_a, pixel_y_a;
    logic [1:0] frame_count_a;
    logic       hsync_b, vsync_b, video_on_b, p_tick_b, line_start_b, frame_start_b;
    logic [2:0] pixel_x_b, pixel_y_b;
    logic [2:0] frame_count_b;

    vga_timing_generator_param #(
        .CLK_DIV(CFG_A.d), .H_ACTIVE(CFG_A.ha), .H_FP(CFG_A.hfp), .H_SYNC(CFG_A.hs), .H_BP(CFG_A.hb),
        .V_ACTIVE(CFG_A.va), .V_FP(CFG_A.vfp), .V_SYNC(CFG_A.vs), .V_BP(CFG_A.vb),
        .HS_POL(CFG_A.hp), .VS_POL(CFG_A.vp), .CW(4), .FRAME_W(2)
    ) dut_a (
        .clk(clk), .reset(reset), .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a),
        .p_tick(p_tick_a), .pixel_x(pixel_x_a), .pixel_y(pixel_y_a), .line_start(line_start_a),
        .frame_start(frame_start_a), .frame_count(frame_count_a)
    );

    vga_timing_generator_param #(
        .CLK_DIV(CFG_B.d), .H_ACTIVE(CFG_B.ha), .H_FP(CFG_B.hfp), .H_SYNC(CFG_B.hs), .H_BP(CFG_B.hb),
        .V_ACTIVE(CFG_B.va), .V_FP(CFG_B.vfp), .V_SYNC(CFG_B.vs), .V_BP(CFG_B.vb),
        .HS_POL(CFG_B.hp), .VS_POL(CFG_B.vp), .CW(3), .FRAME_W(3)
    ) dut_b (
        .clk(clk), .reset(reset), .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b),
        .p_tick(p_tick_b), .pixel_x(pixel_x_b), .pixel_y(pixel_y_b), .line_start(line_start_b),
        .frame_start(frame_start_b), .frame_count(frame_count_b)
    );

    always #5 clk = ~clk;

    // Number of rising edges since the last edge that sampled reset high.
    always @(posedge clk) n_edges <= reset ? 0 : n_edges + 1;

    // Reference: after n post-reset edges, the counters have advanced once
    // for every p_tick cycle that has already been closed by an edge. The
    // ticks occur in the cycles after edges D, 2D, 3D, ...
    function automatic out_t raw(int n, cfg_t c);
        out_t r;
        int ht, vt, p, x, y, hs0, vs0;
        bit upd;
        ht  = c.ha + c.hfp + c.hs + c.hb;
        vt  = c.va + c.vfp + c.vs + c.vb;
        p   = (n >= 1) ? (n - 1) / c.d : 0;
        x   = p % ht;
        y   = (p / ht) % vt;
        upd = (n >= 2) && (((n - 1) % c.d) == 0);
        hs0 = c.ha + c.hfp;
        vs0 = c.va + c.vfp;
        r     = '0;
        r.hs  = ((x >= hs0) && (x < hs0 + c.hs)) ? c.hp[0] : ~c.hp[0];
        r.vs  = ((y >= vs0) && (y < vs0 + c.vs)) ? c.vp[0] : ~c.vp[0];
        r.von = (x < c.ha) && (y < c.va);
        r.pt  = (n >= 1) && ((n % c.d) == 0);
        r.x   = 16'(x);
        r.y   = 16'(y);
        r.ls  = upd && ((p % ht) == 0);
        r.fs  = upd && ((p % (ht * vt)) == 0);
        r.fc  = 8'((p / (ht * vt)) % (1 << c.fw));
        return r;
    endfunction

    function automatic out_t expv(int n, cfg_t c);
        out_t a;
        a = raw(n, c);
`ifdef VGA_TIMING_PIPE_EN
        begin
            out_t b;
            b    = raw((n > 0) ? n - 1 : 0, c);
            b.pt = a.pt;
            b.fc = a.fc;
            return b;
        end
`else
        return a;
`endif
    endfunction

    function automatic out_t obs_a();
        out_t o;
        o = '0;
        o.hs = hsync_a; o.vs = vsync_a; o.von = video_on_a; o.pt = p_tick_a;
        o.x = 16'(pixel_x_a); o.y = 16'(pixel_y_a);
        o.ls = line_start_a; o.fs = frame_start_a; o.fc = 8'(frame_count_a);
        return o;
    endfunction

    function automatic out_t obs_b();
        out_t o;
        o = '0;
        o.hs = hsync_b; o.vs = vsync_b; o.von = video_on_b; o.pt = p_tick_b;
        o.x = 16'(pixel_x_b); o.y = 16'(pixel_y_b);
        o.ls = line_start_b; o.fs = frame_start_b; o.fc = 8'(frame_count_b);
        return o;
    endfunction

    function automatic string fmt(out_t o);
        return $sformatf("hs=%0b vs=%0b von=%0b pt=%0b x=%0d y=%0d ls=%0b fs=%0b fc=%0d",
                         o.hs, o.vs, o.von, o.pt, o.x, o.y, o.ls, o.fs, o.fc);
    endfunction

    task automatic test_reset();
        out_t oa, ob;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        oa = obs_a();
        ob = obs_b();
        checks++;
        if (oa !== expv(0, CFG_A)) begin
            errors++;
            $display("FAIL reset_a got %s want %s", fmt(oa), fmt(expv(0, CFG_A)));
        end
        checks++;
        if (ob !== expv(0, CFG_B)) begin
            errors++;
            $display("FAIL reset_b got %s want %s", fmt(ob), fmt(expv(0, CFG_B)));
        end
        // A: inactive hsync is high, inactive vsync is low. B: the reverse.
        checks++;
        if ({hsync_a, vsync_a, video_on_a, p_tick_a, hsync_b, vsync_b, video_on_b, p_tick_b} !== 8'b1010_0110) begin
            errors++;
            $display("FAIL reset_levels got %b want 10100110",
                     {hsync_a, vsync_a, video_on_a, p_tick_a, hsync_b, vsync_b, video_on_b, p_tick_b});
        end
        reset = 1'b0;
    endtask

    // Cycle-by-cycle comparison against the model, with random short resets.
    task automatic test_random_run(int cycles);
        out_t oa, ob, ea, eb;
        int rst_left;
        rst_left = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            oa = obs_a(); ea = expv(n_edges, CFG_A);
            ob = obs_b(); eb = expv(n_edges, CFG_B);
            checks++;
            if (oa !== ea) begin
                errors++;
                $display("FAIL run_a n=%0d got %s want %s", n_edges, fmt(oa), fmt(ea));
            end
            checks++;
            if (ob !== eb) begin
                errors++;
                $display("FAIL run_b n=%0d got %s want %s", n_edges, fmt(ob), fmt(eb));
            end
            if (rst_left > 0) begin
                rst_left--;
                reset = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
                rst_left = $urandom_range(0, 2);
                reset = 1'b1;
            end else begin
                reset = 1'b0;
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_periods();
        int cnt;
        bit got;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (line_start_a) got = 1;
        end
        cnt = 0;
        if (got) begin
            got = 0;
            for (int i = 0; i < 200 && !got; i++) begin
                @(negedge clk);
                cnt++;
                if (line_start_a) got = 1;
            end
        end
        checks++;
        if (!got || cnt != 45) begin
            errors++;
            $display("FAIL line_period_a got %0d (seen=%0b) want 45", cnt, got);
        end
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (frame_start_b) got = 1;
        end
        cnt = 0;
        if (got) begin
            got = 0;
            for (int i = 0; i < 200 && !got; i++) begin
                @(negedge clk);
                cnt++;
                if (frame_start_b) got = 1;
            end
        end
        checks++;
        if (!got || cnt != 48) begin
            errors++;
            $display("FAIL frame_period_b got %0d (seen=%0b) want 48", cnt, got);
        end
    endtask

    // Counts the active-sync and visible cycles over exactly one frame of each DUT.
    task automatic test_sync_windows();
        int hs_a, vs_a, von_a, xmin, xmax, hs_b, vs_b, von_b;
        bit got;
        hs_a = 0; vs_a = 0; von_a = 0; xmin = 99; xmax = -1;
        got = 0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(negedge clk);
            if (frame_start_a) got = 1;
        end
        for (int i = 0; i < 450; i++) begin
            if (hsync_a == 1'b0) begin
                hs_a++;
                if (int'(pixel_x_a) < xmin) xmin = int'(pixel_x_a);
                if (int'(pixel_x_a) > xmax) xmax = int'(pixel_x_a);
            end
            if (vsync_a == 1'b1) vs_a++;
            if (video_on_a) von_a++;
            @(negedge clk);
        end
        checks++;
        if (!got || hs_a != 90 || xmin != 10 || xmax != 12) begin
            errors++;
            $display("FAIL hsync_window_a got cnt=%0d x=%0d..%0d want cnt=90 x=10..12", hs_a, xmin, xmax);
        end
        checks++;
        if (vs_a != 90) begin
            errors++;
            $display("FAIL vsync_window_a got %0d want 90", vs_a);
        end
        checks++;
        if (von_a != 120) begin
            errors++;
            $display("FAIL video_on_a got %0d want 120", von_a);
        end
        hs_b = 0; vs_b = 0; von_b = 0;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (frame_start_b) got = 1;
        end
        for (int i = 0; i < 48; i++) begin
            if (hsync_b == 1'b1) hs_b++;
            if (vsync_b == 1'b0) vs_b++;
            if (video_on_b) von_b++;
            @(negedge clk);
        end
        checks++;
        if (!got || hs_b != 12 || vs_b != 8 || von_b != 12) begin
            errors++;
            $display("FAIL windows_b got hs=%0d vs=%0d von=%0d want 12 8 12", hs_b, vs_b, von_b);
        end
    endtask

    task automatic test_frame_count();
        int want [5];
        int k;
        want = '{1, 2, 3, 0, 1};
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        k = 0;
        for (int i = 0; i < 2600 && k < 5; i++) begin
            @(negedge clk);
            if (frame_start_a) begin
                checks++;
                if (int'(frame_count_a) != want[k]) begin
                    errors++;
                    $display("FAIL frame_count_%0d got %0d want %0d", k, frame_count_a, want[k]);
                end
                k++;
            end
        end
        checks++;
        if (k != 5) begin
            errors++;
            $display("FAIL frame_count_timeout got %0d frames want 5", k);
        end
    endtask

    task automatic test_mid_frame_reset();
        bit got, seen_fs;
        got = 0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(negedge clk);
            if (pixel_x_a == 4'd7 && pixel_y_a == 4'd4) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL midreset_reach got none want x=7 y=4");
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({pixel_x_a, pixel_y_a, hsync_a, vsync_a, frame_count_a, frame_start_a} !== 13'b0) begin
            if (!(pixel_x_a == 0 && pixel_y_a == 0 && hsync_a && !vsync_a && frame_count_a == 0 && !frame_start_a)) begin
                errors++;
                $display("FAIL midreset_state got x=%0d y=%0d hs=%0b vs=%0b fc=%0d fs=%0b want 0 0 1 0 0 0",
                         pixel_x_a, pixel_y_a, hsync_a, vsync_a, frame_count_a, frame_start_a);
            end
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen_fs = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_start_a) seen_fs = 1;
        end
        checks++;
        if (seen_fs) begin
            errors++;
            $display("FAIL midreset_no_fs got frame_start=1 want 0");
        end
    endtask

    initial begin
        test_reset();
        test_random_run(3000);
        test_periods();
        test_sync_windows();
        test_frame_count();
        test_mid_frame_reset();
        test_random_run(1500);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
